axi_lite_cmd_master: RTL and testbench
======================================

Name: axi_lite_cmd_master

Overview:
- Hardware AXI4-Lite initiator: the master-side counterpart of the dfr_core_top configuration slave.
- Takes single-beat register commands (write or read) from an on-chip sequencer and runs one AXI4-Lite transaction per command on an M_AXI port.
- Returns read data and response code on a valid/ready response channel.
- Lets an embedded controller load sample/weight memories, launch the DFR and read outputs without a processor.

Parameters:
- C_M_AXI_ADDR_WIDTH, 16, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width (32 only).

Ports:
- M_AXI_ACLK  in  1  single clock.
- M_AXI_ARESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  register address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data (0 for writes).
- rsp_resp  out  2  BRESP/RRESP of the transaction.
- busy  out  1  high from command accept until response consumed.
- M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32
- M_AXI_WSTRB  out  4  always 4'hF during W valid, 0 otherwise.
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Reset (async, any state): all outputs 0. State IDLE. Address, data and response registers cleared.
- State IDLE:
  - cmd_ready=1.
  - cmd_valid&cmd_ready: latch addr/wdata/write.
  - Write goes to WR_AW_W; read goes to RD_AR.
  - Valids assert the cycle after accept, registered.
- State WR_AW_W:
  - AWVALID and WVALID asserted together.
  - Each is dropped the cycle after its own handshake (VALID&READY at a clock edge). AW and W may complete in either order or the same cycle.
  - Once both are done, go to WR_B with BREADY=1.
  - AWADDR/WDATA are held stable while the respective valid is high.
- State WR_B:
  - BREADY=1.
  - On BVALID: capture BRESP, rsp_rdata=0, go to RESP. BREADY drops next cycle.
- State RD_AR:
  - ARVALID=1 until ARREADY handshake, then RD_R with RREADY=1.
- State RD_R:
  - RREADY=1.
  - On RVALID: capture RDATA/RRESP, go to RESP.
- State RESP:
  - rsp_valid=1, payload stable until rsp_ready.
  - On handshake go to IDLE; cmd_ready rises the next cycle.
  - Minimum command-to-command period is therefore ≥4 cycles.
- AXI rules:
  - No valid is ever deasserted before its handshake.
  - Valids never depend combinationally on readies.
  - Exactly one outstanding transaction.
  - Unexpected BVALID/RVALID outside WR_B/RD_R are ignored (ready low).
- busy = (state != IDLE).
- SLVERR/DECERR are passed through in rsp_resp; the master does not retry.
- cmd_valid is ignored while not in IDLE.
- Reset mid-transaction: immediate return to IDLE, all valids low. The slave must be reset alongside.

Decomposition:
- Package dfr_axi_pkg:
  - State enum (IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP).
  - AXI response constants OKAY/EXOKAY/SLVERR/DECERR.
  - Register address constants CTRL_REG_ADDR=16'h0000 … NUM_TEST_STEPS_REG_ADDR=16'h0020 and MEM_WINDOW_BASE=16'h0100.
- Single flat module; no sub-module needed.

Test Plan:
- Write CTRL_REG_ADDR=32'h1 with an axi_cfg_regs slave attached → AWADDR=0, WDATA=1, WSTRB=F; rsp_resp=0, rsp_rdata=0; readback of 0x0 gives 32'h1.
- Write 0x0008=100 then read 0x0008 → rsp_rdata=100, rsp_resp=0, busy low after each rsp handshake.
- Bench slave with WREADY 3 cycles before AWREADY, then AWREADY 5 cycles before WREADY → each valid drops exactly one cycle after its handshake; single B consumed.
- Read with ARREADY delayed 7 cycles and RVALID with RRESP=2'b10, RDATA=32'hDEAD_BEEF → rsp_resp=2, rsp_rdata=32'hDEADBEEF.
- rsp_ready held low 10 cycles → rsp_valid and payload stable, cmd_ready=0, new cmd_valid ignored.
- Assert M_AXI_ARESET during WR_AW_W → all outputs 0 asynchronously, state IDLE; next command completes normally.

Source files
------------

// File: rtl/dfr_axi_pkg.sv
// Shared types and constants for the DFR AXI4-Lite command master and its register map.
package dfr_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RESP    = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Configuration slave register map, word aligned.
  localparam logic [15:0] CTRL_REG_ADDR              = 16'h0000;
  localparam logic [15:0] STATUS_REG_ADDR            = 16'h0004;
  localparam logic [15:0] NUM_INIT_SAMPLES_REG_ADDR  = 16'h0008;
  localparam logic [15:0] NUM_TRAIN_SAMPLES_REG_ADDR = 16'h000C;
  localparam logic [15:0] NUM_TEST_SAMPLES_REG_ADDR  = 16'h0010;
  localparam logic [15:0] RESERVOIR_SIZE_REG_ADDR    = 16'h0014;
  localparam logic [15:0] NUM_INIT_STEPS_REG_ADDR    = 16'h0018;
  localparam logic [15:0] NUM_TRAIN_STEPS_REG_ADDR   = 16'h001C;
  localparam logic [15:0] NUM_TEST_STEPS_REG_ADDR    = 16'h0020;
  localparam logic [15:0] MEM_WINDOW_BASE            = 16'h0100;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one register command in, one AXI transaction out,
// read data and response code returned on a valid/ready channel.
module axi_lite_cmd_master
  import dfr_axi_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 16,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  state_e                          state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                      resp_q, resp_d;
  logic                            aw_done_q, aw_done_d;
  logic                            w_done_q, w_done_d;
  logic                            cmd_ready_q, cmd_ready_d;

  // Every AXI output is decoded from registered state only, never from a ready input.
  assign M_AXI_AWVALID = (state_q == WR_AW_W) && !aw_done_q;
  assign M_AXI_WVALID  = (state_q == WR_AW_W) && !w_done_q;
  assign M_AXI_WSTRB   = {(C_M_AXI_DATA_WIDTH/8){M_AXI_WVALID}};
  assign M_AXI_BREADY  = (state_q == WR_B);
  assign M_AXI_ARVALID = (state_q == RD_AR);
  assign M_AXI_RREADY  = (state_q == RD_R);
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? WR_AW_W : RD_AR;
        end
      end
      WR_AW_W: begin
        // AW and W complete independently; leave once both have handshaken.
        aw_done_d = aw_done_q || (M_AXI_AWVALID && M_AXI_AWREADY);
        w_done_d  = w_done_q || (M_AXI_WVALID && M_AXI_WREADY);
        if (aw_done_d && w_done_d) begin
          state_d = WR_B;
        end
      end
      WR_B: begin
        if (M_AXI_BVALID) begin
          resp_d  = M_AXI_BRESP;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RD_AR: begin
        if (M_AXI_ARREADY) begin
          state_d = RD_R;
        end
      end
      RD_R: begin
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          resp_d  = M_AXI_RRESP;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered so cmd_ready stays low through reset and rises the cycle after IDLE is entered.
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a behavioural register-file AXI4-Lite slave.
module tb_axi_lite_cmd_master;
  import dfr_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic [15:0] awaddr, araddr;
  logic        awvalid, awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0, rready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(.C_M_AXI_ADDR_WIDTH(16), .C_M_AXI_DATA_WIDTH(32)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .busy(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Slave model configuration and observations.
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [1:0]  b_resp_cfg = RESP_OKAY, r_resp_cfg = RESP_OKAY;
  logic        r_force = 1'b0;
  logic [31:0] r_force_data = '0;
  logic [31:0] mem [0:63];
  int          cyc = 0, viol = 0, b_count = 0, r_count = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0, ar_hs_cyc = 0, ar_rise_cyc = 0;
  logic [15:0] got_awaddr = '0, got_araddr = '0;
  logic [31:0] got_wdata = '0;
  logic [3:0]  got_wstrb = '0;

  // Slave: acts on negedges; a handshake is seen as last negedge's sampled VALID/READY pair.
  initial begin
    int aw_cnt, w_cnt, ar_cnt;
    logic aw_got, w_got, r_pend, hs_aw, hs_w, hs_ar, hs_b, hs_r;
    logic s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready;
    logic [15:0] s_awaddr, s_araddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    aw_got = 0; w_got = 0; r_pend = 0;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_got = 0; w_got = 0; r_pend = 0;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
      end else begin
        hs_aw = s_awvalid && awready;
        hs_w  = s_wvalid && wready;
        hs_ar = s_arvalid && arready;
        hs_b  = bvalid && s_bready;
        hs_r  = rvalid && s_rready;
        if (s_awvalid && !hs_aw && (!awvalid || awaddr !== s_awaddr)) viol++;
        if (s_wvalid && !hs_w && (!wvalid || wdata !== s_wdata)) viol++;
        if (s_arvalid && !hs_ar && (!arvalid || araddr !== s_araddr)) viol++;
        if (hs_aw && awvalid) viol++;
        if (hs_w && wvalid) viol++;
        if (hs_ar && arvalid) viol++;
        if (hs_b && bready) viol++;
        if (hs_r && rready) viol++;
        if (wstrb !== (wvalid ? 4'hF : 4'h0)) viol++;
        if (arvalid && !s_arvalid) ar_rise_cyc = cyc;
        if (hs_aw) begin aw_got = 1; got_awaddr = s_awaddr; aw_hs_cyc = cyc; end
        if (hs_w)  begin w_got = 1; got_wdata = s_wdata; got_wstrb = s_wstrb; w_hs_cyc = cyc; end
        if (hs_ar) begin r_pend = 1; got_araddr = s_araddr; ar_hs_cyc = cyc; end
        if (hs_b)  begin bvalid = 0; b_count++; end
        if (hs_r)  begin rvalid = 0; r_count++; end
        if (aw_got && w_got && !bvalid) begin
          mem[got_awaddr[7:2]] = got_wdata;
          bvalid = 1; bresp = b_resp_cfg; aw_got = 0; w_got = 0;
        end
        if (r_pend && !rvalid) begin
          rvalid = 1; rresp = r_resp_cfg; r_pend = 0;
          rdata = r_force ? r_force_data : mem[got_araddr[7:2]];
        end
        s_awvalid = awvalid; s_awaddr = awaddr;
        s_wvalid = wvalid; s_wdata = wdata; s_wstrb = wstrb;
        s_arvalid = arvalid; s_araddr = araddr;
        s_bready = bready; s_rready = rready;
        if (awvalid) begin
          if (aw_cnt >= aw_delay) awready = 1; else begin awready = 0; aw_cnt++; end
        end else begin awready = 0; aw_cnt = 0; end
        if (wvalid) begin
          if (w_cnt >= w_delay) wready = 1; else begin wready = 0; w_cnt++; end
        end else begin wready = 0; w_cnt = 0; end
        if (arvalid) begin
          if (ar_cnt >= ar_delay) arready = 1; else begin arready = 0; ar_cnt++; end
        end else begin arready = 0; ar_cnt = 0; end
      end
    end
  end

  // Issues one command and consumes its response immediately; to flags an expired wait.
  task automatic do_cmd(input logic wr, input logic [15:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic [1:0] rs, output logic to);
    int n;
    to = 0; rd = '0; rs = '0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) to = 1;
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) to = 1;
    rd = rsp_rdata; rs = rsp_resp;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    $display("txn %s addr=%h wdata=%h rdata=%h resp=%0d timeout=%0d",
             wr ? "WR" : "RD", a, d, rd, rs, to);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cmd_ready, busy, rsp_valid} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ctl: got %b expected 000", {cmd_ready, busy, rsp_valid});
    end
    vectors++;
    if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin
      miscompares++; $display("FAIL reset_axi: got %b expected 00000", {awvalid, wvalid, arvalid, bready, rready});
    end
    vectors++;
    if ({wstrb, awaddr, araddr, wdata, rsp_rdata, rsp_resp} !== '0) begin
      miscompares++; $display("FAIL reset_data: got nonzero payload, expected all 0");
    end
    rst = 0;
    @(negedge clk);
    vectors++;
    if ({cmd_ready, busy} !== 2'b10) begin
      miscompares++; $display("FAIL reset_release: got %b expected 10", {cmd_ready, busy});
    end
  endtask

  task automatic test_write_ctrl();
    logic [31:0] rd; logic [1:0] rs; logic to; int b0;
    b0 = b_count;
    do_cmd(1'b1, CTRL_REG_ADDR, 32'h1, rd, rs, to);
    vectors++;
    if ({to, got_awaddr, got_wdata, got_wstrb} !== {1'b0, 16'h0000, 32'h1, 4'hF}) begin
      miscompares++;
      $display("FAIL ctrl_wr_bus: got to=%0d aw=%h w=%h strb=%h expected 0 0000 00000001 f",
               to, got_awaddr, got_wdata, got_wstrb);
    end
    vectors++;
    if ({rs, rd, busy} !== {2'b00, 32'h0, 1'b0}) begin
      miscompares++; $display("FAIL ctrl_wr_rsp: got resp=%0d rdata=%h busy=%b expected 0 0 0", rs, rd, busy);
    end
    vectors++;
    if (b_count !== b0 + 1) begin
      miscompares++; $display("FAIL ctrl_wr_b: got %0d B beats expected 1", b_count - b0);
    end
    do_cmd(1'b0, CTRL_REG_ADDR, 32'h0, rd, rs, to);
    vectors++;
    if ({to, rs, rd} !== {1'b0, 2'b00, 32'h1}) begin
      miscompares++; $display("FAIL ctrl_rd: got to=%0d resp=%0d rdata=%h expected 0 0 00000001", to, rs, rd);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic [1:0] rs; logic to;
    do_cmd(1'b1, NUM_INIT_SAMPLES_REG_ADDR, 32'd100, rd, rs, to);
    vectors++;
    if ({to, rs, rd, busy} !== {1'b0, 2'b00, 32'h0, 1'b0}) begin
      miscompares++; $display("FAIL wr8_rsp: got to=%0d resp=%0d rdata=%h busy=%b expected 0 0 0 0", to, rs, rd, busy);
    end
    do_cmd(1'b0, NUM_INIT_SAMPLES_REG_ADDR, 32'h0, rd, rs, to);
    vectors++;
    if ({to, rs, rd, busy} !== {1'b0, 2'b00, 32'd100, 1'b0}) begin
      miscompares++; $display("FAIL rd8_rsp: got to=%0d resp=%0d rdata=%0d busy=%b expected 0 0 100 0", to, rs, rd, busy);
    end
    vectors++;
    if (got_araddr !== 16'h0008) begin
      miscompares++; $display("FAIL rd8_araddr: got %h expected 0008", got_araddr);
    end
  endtask

  task automatic test_skew();
    logic [31:0] rd; logic [1:0] rs; logic to; int b0, v0;
    v0 = viol; b0 = b_count;
    aw_delay = 3; w_delay = 0;
    do_cmd(1'b1, NUM_TRAIN_SAMPLES_REG_ADDR, 32'h1234_5678, rd, rs, to);
    vectors++;
    if (aw_hs_cyc - w_hs_cyc !== 3 || to !== 1'b0) begin
      miscompares++; $display("FAIL skew_w_first: got gap=%0d to=%0d expected 3 0", aw_hs_cyc - w_hs_cyc, to);
    end
    aw_delay = 0; w_delay = 5;
    do_cmd(1'b1, NUM_INIT_STEPS_REG_ADDR, 32'hCAFE_0001, rd, rs, to);
    vectors++;
    if (w_hs_cyc - aw_hs_cyc !== 5 || to !== 1'b0) begin
      miscompares++; $display("FAIL skew_aw_first: got gap=%0d to=%0d expected 5 0", w_hs_cyc - aw_hs_cyc, to);
    end
    w_delay = 0;
    vectors++;
    if (b_count - b0 !== 2) begin
      miscompares++; $display("FAIL skew_b: got %0d B beats expected 2", b_count - b0);
    end
    vectors++;
    if (viol !== v0) begin
      miscompares++; $display("FAIL skew_protocol: got %0d violations expected 0", viol - v0);
    end
    do_cmd(1'b0, NUM_TRAIN_SAMPLES_REG_ADDR, 32'h0, rd, rs, to);
    vectors++;
    if (rd !== 32'h1234_5678) begin
      miscompares++; $display("FAIL skew_readback: got %h expected 12345678", rd);
    end
  endtask

  task automatic test_error_resp();
    logic [31:0] rd; logic [1:0] rs; logic to; int v0;
    v0 = viol;
    ar_delay = 7; r_force = 1; r_force_data = 32'hDEAD_BEEF; r_resp_cfg = RESP_SLVERR;
    do_cmd(1'b0, STATUS_REG_ADDR, 32'h0, rd, rs, to);
    vectors++;
    if ({to, rs, rd} !== {1'b0, 2'b10, 32'hDEAD_BEEF}) begin
      miscompares++; $display("FAIL rd_slverr: got to=%0d resp=%0d rdata=%h expected 0 2 deadbeef", to, rs, rd);
    end
    vectors++;
    if (ar_hs_cyc - ar_rise_cyc !== 8 || viol !== v0) begin
      miscompares++; $display("FAIL rd_ar_wait: got hs_gap=%0d viol=%0d expected 8 0", ar_hs_cyc - ar_rise_cyc, viol - v0);
    end
    ar_delay = 0; r_force = 0; r_resp_cfg = RESP_OKAY;
    b_resp_cfg = RESP_DECERR;
    do_cmd(1'b1, NUM_TRAIN_STEPS_REG_ADDR, 32'h7, rd, rs, to);
    b_resp_cfg = RESP_OKAY;
    vectors++;
    if ({to, rs, rd} !== {1'b0, 2'b11, 32'h0}) begin
      miscompares++; $display("FAIL wr_decerr: got to=%0d resp=%0d rdata=%h expected 0 3 0", to, rs, rd);
    end
  endtask

  task automatic test_rsp_stall();
    logic [31:0] rd; logic [1:0] rs; logic to; int n;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = NUM_INIT_SAMPLES_REG_ADDR;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = NUM_TEST_SAMPLES_REG_ADDR; cmd_wdata = 32'h55;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({rsp_valid, rsp_rdata, rsp_resp} !== {1'b1, 32'd100, 2'b00}) begin
        miscompares++; $display("FAIL stall_payload[%0d]: got v=%b d=%h r=%0d expected 1 00000064 0", i, rsp_valid, rsp_rdata, rsp_resp);
      end
      vectors++;
      if ({cmd_ready, awvalid, arvalid, busy} !== 4'b0001) begin
        miscompares++; $display("FAIL stall_cmd[%0d]: got %b expected 0001", i, {cmd_ready, awvalid, arvalid, busy});
      end
      @(negedge clk);
    end
    cmd_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    $display("txn RD addr=0008 stalled 10 cycles, released");
    vectors++;
    if ({busy, cmd_ready, rsp_valid} !== 3'b010) begin
      miscompares++; $display("FAIL stall_release: got %b expected 010", {busy, cmd_ready, rsp_valid});
    end
    do_cmd(1'b0, NUM_TEST_SAMPLES_REG_ADDR, 32'h0, rd, rs, to);
    vectors++;
    if ({to, rd} !== {1'b0, 32'h0}) begin
      miscompares++; $display("FAIL stall_ignored_cmd: got to=%0d rdata=%h expected 0 0", to, rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic [1:0] rs; logic to; int n;
    aw_delay = 20; w_delay = 20;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = RESERVOIR_SIZE_REG_ADDR; cmd_wdata = 32'hBAD;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 0;
    vectors++;
    if ({awvalid, wvalid, busy} !== 3'b111) begin
      miscompares++; $display("FAIL mid_state: got %b expected 111", {awvalid, wvalid, busy});
    end
    #2 rst = 1;
    #1;
    vectors++;
    if ({awvalid, wvalid, arvalid, bready, rready, busy, cmd_ready, rsp_valid, wstrb} !== 12'h0) begin
      miscompares++; $display("FAIL mid_async_ctl: got %b expected 0",
                              {awvalid, wvalid, arvalid, bready, rready, busy, cmd_ready, rsp_valid, wstrb});
    end
    vectors++;
    if ({awaddr, wdata} !== 48'h0) begin
      miscompares++; $display("FAIL mid_async_data: got aw=%h w=%h expected 0 0", awaddr, wdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    aw_delay = 0; w_delay = 0;
    do_cmd(1'b1, RESERVOIR_SIZE_REG_ADDR, 32'hA5A5, rd, rs, to);
    vectors++;
    if ({to, rs} !== 3'b000) begin
      miscompares++; $display("FAIL mid_next_wr: got to=%0d resp=%0d expected 0 0", to, rs);
    end
    do_cmd(1'b0, RESERVOIR_SIZE_REG_ADDR, 32'h0, rd, rs, to);
    vectors++;
    if ({to, rd} !== {1'b0, 32'hA5A5}) begin
      miscompares++; $display("FAIL mid_readback: got to=%0d rdata=%h expected 0 0000a5a5", to, rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_ctrl();
    test_write_read();
    test_skew();
    test_error_resp();
    test_rsp_stall();
    test_reset_mid();
    vectors++;
    if (viol !== 0) begin
      miscompares++; $display("FAIL protocol_total: got %0d violations expected 0", viol);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 expected earlier finish");
    $fatal(1);
  end

endmodule
